// File: rtl/psum_pkg.sv
// -----------------------------------------------------------------------------
// psum_pkg
// Shared types and geometry for the PSUM accumulation stage.
//   - lane / vector / address typedefs
//   - FSM state enum
//   - kernel-offset decode helper (kij -> ki, kj, legal)
// -----------------------------------------------------------------------------
package psum_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_BW = 11;
    localparam int NIJ_SZ  = 6;
    localparam int ONIJ_SZ = 4;
    localparam int KW      = 3;
    localparam int LEN_NIJ = NIJ_SZ * NIJ_SZ;
    localparam int KIJ_BW  = 4;
    localparam int NIJ_BW  = 6;
    // Wide enough for a row/column index 0..NIJ_SZ-1 and for ki/kj.
    localparam int POS_BW  = 3;

    typedef logic [PSUM_BW-1:0]     lane_t;
    typedef logic [COL*PSUM_BW-1:0] vec_t;
    typedef logic [ADDR_BW-1:0]     addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              legal;
        logic [POS_BW-1:0] ki;
        logic [POS_BW-1:0] kj;
    } koff_t;

    // Split kij into kernel row/column; kij outside 0..KW*KW-1 is flagged
    // illegal so the whole pass runs with every vector out of window.
    function automatic koff_t kij_decode(input logic [KIJ_BW-1:0] kij);
        koff_t k;
        k.legal = 1'b1;
        k.ki    = 3'd0;
        k.kj    = 3'd0;
        case (kij)
            4'd0:    begin k.ki = 3'd0; k.kj = 3'd0; end
            4'd1:    begin k.ki = 3'd0; k.kj = 3'd1; end
            4'd2:    begin k.ki = 3'd0; k.kj = 3'd2; end
            4'd3:    begin k.ki = 3'd1; k.kj = 3'd0; end
            4'd4:    begin k.ki = 3'd1; k.kj = 3'd1; end
            4'd5:    begin k.ki = 3'd1; k.kj = 3'd2; end
            4'd6:    begin k.ki = 3'd2; k.kj = 3'd0; end
            4'd7:    begin k.ki = 3'd2; k.kj = 3'd1; end
            4'd8:    begin k.ki = 3'd2; k.kj = 3'd2; end
            default: begin k.legal = 1'b0; end
        endcase
        return k;
    endfunction

endpackage

// File: rtl/psum_acc_stage_if.sv
// -----------------------------------------------------------------------------
// psum_acc_stage_if
// Data-path bus of the accumulation stage: OFIFO pop side and the two-port
// PSUM memory side.
//   master : the accumulation stage (pops OFIFO, drives pmem read/write)
//   slave  : the OFIFO + pmem environment
// Signals
//   ofifo_valid / ofifo_data : FWFT OFIFO head, ofifo_rd pops it
//   pmem_rcen / pmem_raddr   : active-low read, data on pmem_rdata next cycle
//   pmem_wcen / pmem_waddr / pmem_wdata : active-low write port
// -----------------------------------------------------------------------------
interface psum_acc_stage_if;
    import psum_pkg::*;

    logic  ofifo_valid;
    logic  ofifo_rd;
    vec_t  ofifo_data;
    logic  pmem_rcen;
    addr_t pmem_raddr;
    vec_t  pmem_rdata;
    logic  pmem_wcen;
    addr_t pmem_waddr;
    vec_t  pmem_wdata;

    modport master (
        input  ofifo_valid, ofifo_data, pmem_rdata,
        output ofifo_rd, pmem_rcen, pmem_raddr, pmem_wcen, pmem_waddr, pmem_wdata
    );

    modport slave (
        output ofifo_valid, ofifo_data, pmem_rdata,
        input  ofifo_rd, pmem_rcen, pmem_raddr, pmem_wcen, pmem_waddr, pmem_wdata
    );

endinterface

// File: rtl/psum_lane_alu.sv
// -----------------------------------------------------------------------------
// psum_lane_alu
// One lane of the accumulate datapath: bypass (first kernel pass) or
// wrap-around add with the stored partial sum, then optional ReLU.
// Ports
//   psum_i   : lane from the OFIFO vector
//   pmem_i   : lane read back from pmem
//   bypass_i : 1 = overwrite with psum_i, ignore pmem_i
//   relu_i   : 1 = clamp negative results to zero
//   sum_o    : lane result (combinational, registered by the parent)
// -----------------------------------------------------------------------------
module psum_lane_alu
    import psum_pkg::*;
(
    input  lane_t psum_i,
    input  lane_t pmem_i,
    input  logic  bypass_i,
    input  logic  relu_i,
    output lane_t sum_o
);

    lane_t add_s;

    // Add or bypass, then ReLU on the sign bit of the wrapped result.
    always_comb begin
        add_s = psum_i;
        sum_o = psum_i;
        if (bypass_i) begin
            add_s = psum_i;
        end else begin
            add_s = psum_i + pmem_i;
        end
        if (relu_i && add_s[PSUM_BW-1]) begin
            sum_o = {PSUM_BW{1'b0}};
        end else begin
            sum_o = add_s;
        end
    end

endmodule

// File: rtl/psum_acc_stage.sv
// -----------------------------------------------------------------------------
// psum_acc_stage
// Accumulation stage between the core OFIFO and the PSUM memory. One pass per
// kernel index kij pops LEN_NIJ vectors, maps each input position nij to its
// output address and read-modify-writes the in-window ones into pmem
// (overwrite when kij==0, accumulate otherwise). Out-of-window vectors are
// popped and dropped.
// Ports
//   clk, reset : clock and synchronous active-high reset
//   start      : pass request, accepted in IDLE only (kij, relu latched)
//   kij, relu  : kernel index and ReLU-on-write for this pass
//   busy       : high from start accept until the done cycle ends
//   done       : one-cycle pulse after the last write of the pass
//   bus        : OFIFO/pmem bus (master side)
// Pipeline: pop/read at t, add at t+1, write at t+2.
// -----------------------------------------------------------------------------
module psum_acc_stage
    import psum_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [KIJ_BW-1:0] kij,
    input  logic              relu,
    output logic              busy,
    output logic              done,
    psum_acc_stage_if.master  bus
);

    // Control state
    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [NIJ_BW-1:0] nij_q;
    logic [POS_BW-1:0] row_q;
    logic [POS_BW-1:0] col_q;
    logic              drain_q;
    koff_t             koff_q;
    logic              kij_zero_q;
    logic              relu_q;

    // Pipeline registers
    logic              s1_valid_q;
    addr_t             s1_addr_q;
    vec_t              s1_vec_q;
    logic              wcen_q;
    addr_t             waddr_q;
    vec_t              wdata_q;

    // Combinational address map
    logic              pop_s;
    logic [POS_BW-1:0] row_off_s;
    logic [POS_BW-1:0] col_off_s;
    logic              in_win_s;
    logic              rd_s;
    addr_t             addr_s;
    vec_t              sum_s;

    // Map the current nij (tracked as row/col counters) to the output window.
    always_comb begin
        pop_s     = 1'b0;
        row_off_s = row_q - koff_q.ki;
        col_off_s = col_q - koff_q.kj;
        in_win_s  = 1'b0;
        rd_s      = 1'b0;
        addr_s    = ADDR_BW'(row_off_s) * ADDR_BW'(NIJ_SZ) + ADDR_BW'(col_off_s);
        if (state_q == RUN) begin
            pop_s = bus.ofifo_valid;
        end else begin
            pop_s = 1'b0;
        end
        // The >= tests reject the negative offsets that wrap in row_off/col_off.
        if (koff_q.legal &&
            (row_q >= koff_q.ki) && (row_off_s < POS_BW'(ONIJ_SZ)) &&
            (col_q >= koff_q.kj) && (col_off_s < POS_BW'(ONIJ_SZ))) begin
            in_win_s = 1'b1;
        end else begin
            in_win_s = 1'b0;
        end
        // The first kernel pass overwrites, so the old row is not needed.
        if (pop_s && in_win_s && !kij_zero_q) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
    end

    assign bus.ofifo_rd   = pop_s;
    assign bus.pmem_rcen  = ~rd_s;
    assign bus.pmem_raddr = rd_s ? addr_s : {ADDR_BW{1'b0}};
    assign bus.pmem_wcen  = wcen_q;
    assign bus.pmem_waddr = waddr_q;
    assign bus.pmem_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // Per-lane add/bypass/ReLU on the vector captured at the pop cycle.
    for (genvar j = 0; j < COL; j++) begin : g_lane
        psum_lane_alu u_alu (
            .psum_i   (s1_vec_q[j*PSUM_BW +: PSUM_BW]),
            .pmem_i   (bus.pmem_rdata[j*PSUM_BW +: PSUM_BW]),
            .bypass_i (kij_zero_q),
            .relu_i   (relu_q),
            .sum_o    (sum_s[j*PSUM_BW +: PSUM_BW])
        );
    end

    // Pass FSM with pop counter and registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nij_q      <= 6'd0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            drain_q    <= 1'b0;
            koff_q     <= '{legal: 1'b0, ki: 3'd0, kj: 3'd0};
            kij_zero_q <= 1'b0;
            relu_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        koff_q     <= kij_decode(kij);
                        kij_zero_q <= (kij == 4'd0);
                        relu_q     <= relu;
                        nij_q      <= 6'd0;
                        row_q      <= 3'd0;
                        col_q      <= 3'd0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                RUN: begin
                    if (pop_s) begin
                        if (nij_q == NIJ_BW'(LEN_NIJ - 1)) begin
                            nij_q   <= 6'd0;
                            row_q   <= 3'd0;
                            col_q   <= 3'd0;
                            drain_q <= 1'b0;
                            state_q <= DRAIN;
                        end else begin
                            nij_q <= nij_q + 6'd1;
                            if (col_q == POS_BW'(NIJ_SZ - 1)) begin
                                col_q <= 3'd0;
                                row_q <= row_q + 3'd1;
                            end else begin
                                col_q <= col_q + 3'd1;
                            end
                        end
                    end else begin
                        state_q <= RUN;
                    end
                end
                DRAIN: begin
                    // Two cycles let the last popped vector reach the write port.
                    if (drain_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Capture/add/write pipeline; reset squashes anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= {ADDR_BW{1'b0}};
            s1_vec_q   <= {(COL*PSUM_BW){1'b0}};
            wcen_q     <= 1'b1;
            waddr_q    <= {ADDR_BW{1'b0}};
            wdata_q    <= {(COL*PSUM_BW){1'b0}};
        end else begin
            s1_valid_q <= pop_s && in_win_s;
            s1_addr_q  <= addr_s;
            s1_vec_q   <= bus.ofifo_data;
            wcen_q     <= ~s1_valid_q;
            if (s1_valid_q) begin
                waddr_q <= s1_addr_q;
                wdata_q <= sum_s;
            end else begin
                waddr_q <= waddr_q;
                wdata_q <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_psum_acc_stage.sv
// -----------------------------------------------------------------------------
// tb_psum_acc_stage
// Directed bench for psum_acc_stage with an OFIFO source and a pmem model.
// -----------------------------------------------------------------------------
module tb_psum_acc_stage;
    import psum_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [KIJ_BW-1:0] kij;
    logic              relu;
    logic              busy;
    logic              done;

    psum_acc_stage_if bus ();

    psum_acc_stage dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .kij   (kij),
        .relu  (relu),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // pmem model: synchronous read (data next cycle), synchronous write.
    vec_t mem [0:63];
    vec_t rdata_q;
    logic preload_req;
    vec_t preload_val;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= preload_val;
        end else if (!bus.pmem_wcen) begin
            mem[bus.pmem_waddr[5:0]] <= bus.pmem_wdata;
        end
        if (!bus.pmem_rcen) rdata_q <= mem[bus.pmem_raddr[5:0]];
    end
    assign bus.pmem_rdata = rdata_q;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    pop_idx, n_pops, done_cnt, done_cyc, last_wr_cyc, busy_gap;
    addr_t wr_addr [$];
    vec_t  wr_data [$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic vec_t fill(input logic [15:0] v);
        vec_t r;
        for (int j = 0; j < COL; j++) r[j*PSUM_BW +: PSUM_BW] = v;
        return r;
    endfunction

    task automatic preload(input logic [15:0] v);
        preload_val = fill(v);
        preload_req = 1'b1;
        @(posedge clk);
        #1 preload_req = 1'b0;
    endtask

    task automatic drive_vec(input logic vmode, input logic [15:0] vconst);
        logic [31:0] p;
        p = pop_idx;
        bus.ofifo_data = vmode ? fill(vconst) : fill(p[15:0]);
    endtask

    // One full pass: start, then monitor writes/done/busy/pops cycle by cycle.
    task automatic run_pass(input logic [3:0] k, input logic r, input logic vmode,
                            input logic [15:0] vconst, input logic toggle);
        logic pop;
        logic fin;
        wr_addr.delete();
        wr_data.delete();
        pop_idx = 0; n_pops = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; busy_gap = 0;
        fin = 1'b0;
        drive_vec(vmode, vconst);
        bus.ofifo_valid = 1'b1;
        kij = k; relu = r; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (!bus.pmem_wcen) begin
                wr_addr.push_back(bus.pmem_waddr);
                wr_data.push_back(bus.pmem_wdata);
                last_wr_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!busy && done_cnt == 0) busy_gap++;
            pop = bus.ofifo_rd;
            @(posedge clk);
            #1;
            if (pop) begin pop_idx++; n_pops++; end
            drive_vec(vmode, vconst);
            if (toggle) bus.ofifo_valid = ~bus.ofifo_valid;
            if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1'b1;
        end
        bus.ofifo_valid = 1'b1;
    endtask

    // kind 0: data = addr, kind 1: data = addr + 107, kind 2: data = cval.
    task automatic verify(input string tag, input int kind, input logic [15:0] cval, input logic exact_done);
        int          exp_a;
        logic [15:0] exp_d;
        check_eq({tag, "_nwr"}, wr_addr.size(), 16);
        check_eq({tag, "_npop"}, n_pops, 36);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_busy_gap"}, busy_gap, 0);
        if (exact_done) check_eq({tag, "_done_cyc"}, done_cyc, last_wr_cyc + 1);
        else            check_eq({tag, "_done_after_wr"}, (done_cyc > last_wr_cyc), 1);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            exp_a = (i / 4) * 6 + (i % 4);
            if (kind == 0)      exp_d = 16'(exp_a);
            else if (kind == 1) exp_d = 16'(exp_a + 107);
            else                exp_d = cval;
            check_eq($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_a);
            check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], fill(exp_d));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_after, done_after, busy_after;
        reset = 1'b1; start = 1'b0; kij = 4'd0; relu = 1'b0;
        bus.ofifo_valid = 1'b1; bus.ofifo_data = fill(16'd0);
        preload_req = 1'b0; preload_val = fill(16'd0);
        pop_idx = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ofifo_rd", bus.ofifo_rd, 0);
        check_eq("rst_rcen", bus.pmem_rcen, 1);
        check_eq("rst_wcen", bus.pmem_wcen, 1);
        check_eq("rst_raddr", bus.pmem_raddr, 0);
        check_eq("rst_waddr", bus.pmem_waddr, 0);
        check_eq("rst_wdata", bus.pmem_wdata, 0);
        #1 reset = 1'b0;
        preload(16'd0);

        // 1: first kernel pass overwrites with the vector index
        run_pass(4'd0, 1'b0, 1'b0, 16'd0, 1'b0);
        verify("s1", 0, 16'd0, 1'b0);

        // 2: centre kernel accumulates onto 100
        preload(16'd100);
        run_pass(4'd4, 1'b0, 1'b0, 16'd0, 1'b0);
        verify("s2", 1, 16'd0, 1'b0);

        // 3: last kernel with ReLU, -50 + 10 -> 0, -50 + 60 -> 10
        preload(16'hFFCE);
        run_pass(4'd8, 1'b1, 1'b1, 16'd10, 1'b0);
        verify("s3a", 2, 16'd0, 1'b1);
        preload(16'hFFCE);
        run_pass(4'd8, 1'b1, 1'b1, 16'd60, 1'b0);
        verify("s3b", 2, 16'd10, 1'b1);

        // 4: OFIFO valid toggling every cycle
        run_pass(4'd0, 1'b0, 1'b0, 16'd0, 1'b1);
        verify("s4", 0, 16'd0, 1'b0);

        // 5: reset five cycles into RUN
        kij = 4'd0; relu = 1'b0; pop_idx = 0; drive_vec(1'b0, 16'd0);
        bus.ofifo_valid = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wr_after = 0; done_after = 0; busy_after = 0;
        @(negedge clk);
        check_eq("s5_rd_after_rst", bus.ofifo_rd, 0);
        check_eq("s5_rcen_after_rst", bus.pmem_rcen, 1);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (!bus.pmem_wcen) wr_after++;
            if (done) done_after++;
            if (busy) busy_after++;
        end
        check_eq("s5_writes_after_rst", wr_after, 0);
        check_eq("s5_done_after_rst", done_after, 0);
        check_eq("s5_busy_after_rst", busy_after, 0);
        run_pass(4'd0, 1'b0, 1'b0, 16'd0, 1'b0);
        verify("s5_rerun", 0, 16'd0, 1'b0);

        // 6: wrap-around 0x7FFF + 1, then the same with ReLU
        preload(16'h7FFF);
        run_pass(4'd1, 1'b0, 1'b1, 16'd1, 1'b0);
        verify("s6_wrap", 2, 16'h8000, 1'b0);
        preload(16'h7FFF);
        run_pass(4'd1, 1'b1, 1'b1, 16'd1, 1'b0);
        verify("s6_relu", 2, 16'h0000, 1'b0);

        // Illegal kij: full pass of pops, no writes, done still pulses
        run_pass(4'd9, 1'b0, 1'b0, 16'd0, 1'b0);
        check_eq("noop_nwr", wr_addr.size(), 0);
        check_eq("noop_npop", n_pops, 36);
        check_eq("noop_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
